vr_word_packer: RTL and testbench



---
 rtl/fifo_stream_pkg.sv | 26 ++
 rtl/vr_word_packer.sv | 107 ++++++++++
 tb/tb_vr_word_packer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared lane/keep helpers for the valid/ready stream stages
//
// Purpose: helpers shared by the FIFO stage and the word packer.
//   cnt_width : width of a counter that must hold 0..ratio
//   lane_off  : bit offset of lane i in a packed wide beat
//   keep_mask : mask with the k lowest bits set (k <= MAX_LANES)
package fifo_stream_pkg;

    localparam int MAX_LANES = 32;

    function automatic int cnt_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    function automatic int unsigned lane_off(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    function automatic logic [MAX_LANES-1:0] keep_mask(input int unsigned k);
        if (k >= MAX_LANES) begin
            return '1;
        end
        return (MAX_LANES'(1) << k) - MAX_LANES'(1);
    endfunction

endpackage

// File: rtl/vr_word_packer.sv
// rtl/vr_word_packer.sv - packs RATIO narrow valid/ready words into one wide beat
//
// Purpose: accumulates narrow words (first word in the LSB lane) and presents
// each completed or early-closed group as one wide beat with keep/last.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   up_valid/up_ready narrow-side handshake, wr_data narrow word, up_last early close
//   down_valid/ready  wide-side handshake, rd_data packed beat
//   down_keep         contiguous lane-valid mask, down_last beat closed by up_last
//   fill_level        lanes filled in the group under accumulation
module vr_word_packer
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int RATIO = 4,
    parameter int CNT_W = cnt_width(RATIO)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     up_last,
    output logic                     down_valid,
    input  logic                     down_ready,
    output logic [WIDTH*RATIO-1:0]   rd_data,
    output logic [RATIO-1:0]         down_keep,
    output logic                     down_last,
    output logic [CNT_W-1:0]         fill_level
);

    logic [WIDTH*RATIO-1:0] acc_q, acc_d;
    logic [RATIO-1:0]       keep_q, keep_d, keep_new;
    logic [CNT_W-1:0]       fill_q, fill_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;

    logic                   in_fire, out_fire, close;
    logic [CNT_W-1:0]       lane_sel;

    assign up_ready = ~valid_q | down_ready;
    assign in_fire  = up_valid & up_ready;
    assign out_fire = valid_q & down_ready;

    // A word accepted while a beat is held can only arrive together with that
    // beat leaving, so it always starts a fresh group in lane 0.
    assign lane_sel = valid_q ? '0 : fill_q;
    assign close    = in_fire & ((lane_sel == CNT_W'(RATIO - 1)) | up_last);
    assign keep_new = RATIO'(keep_mask(32'(lane_sel) + 32'd1));

    // Lane write decoder: the selected lane takes the new word, every other
    // lane is cleared when the held beat leaves, otherwise it holds.
    for (genvar i = 0; i < RATIO; i++) begin : g_lane
        assign acc_d[lane_off(i, WIDTH) +: WIDTH] =
            (in_fire && (lane_sel == CNT_W'(i))) ? wr_data :
            out_fire                             ? '0      :
                                                   acc_q[lane_off(i, WIDTH) +: WIDTH];
    end

    always_comb begin
        keep_d  = keep_q;
        fill_d  = fill_q;
        valid_d = valid_q;
        last_d  = last_q;

        if (out_fire) begin
            keep_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            fill_d  = '0;
        end

        if (in_fire) begin
            keep_d = keep_new;
            if (close) begin
                valid_d = 1'b1;
                last_d  = up_last;
                fill_d  = '0;
            end else begin
                fill_d  = lane_sel + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '0;
            keep_q  <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            keep_q  <= keep_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign down_valid = valid_q;
    assign rd_data    = acc_q;
    assign down_keep  = keep_q;
    assign down_last  = last_q;
    assign fill_level = fill_q;

endmodule

// File: tb/tb_vr_word_packer.sv
// tb/tb_vr_word_packer.sv - directed self-checking bench for vr_word_packer
module tb_vr_word_packer;

    localparam int W   = 7;
    localparam int R   = 4;
    localparam int CW  = $clog2(R + 1);
    localparam int RB  = 1;
    localparam int CWB = $clog2(RB + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            a_up_valid, a_up_ready, a_up_last;
    logic [W-1:0]    a_wr_data;
    logic            a_down_valid, a_down_ready, a_down_last;
    logic [W*R-1:0]  a_rd_data;
    logic [R-1:0]    a_down_keep;
    logic [CW-1:0]   a_fill;

    logic            b_up_valid, b_up_ready, b_up_last;
    logic [W-1:0]    b_wr_data;
    logic            b_down_valid, b_down_ready, b_down_last;
    logic [W*RB-1:0] b_rd_data;
    logic [RB-1:0]   b_down_keep;
    logic [CWB-1:0]  b_fill;

    vr_word_packer #(.WIDTH(W), .RATIO(R)) dut_a (
        .clk(clk), .rst(rst),
        .up_valid(a_up_valid), .up_ready(a_up_ready), .wr_data(a_wr_data), .up_last(a_up_last),
        .down_valid(a_down_valid), .down_ready(a_down_ready), .rd_data(a_rd_data),
        .down_keep(a_down_keep), .down_last(a_down_last), .fill_level(a_fill)
    );

    vr_word_packer #(.WIDTH(W), .RATIO(RB)) dut_b (
        .clk(clk), .rst(rst),
        .up_valid(b_up_valid), .up_ready(b_up_ready), .wr_data(b_wr_data), .up_last(b_up_last),
        .down_valid(b_down_valid), .down_ready(b_down_ready), .rd_data(b_rd_data),
        .down_keep(b_down_keep), .down_last(b_down_last), .fill_level(b_fill)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W*R-1:0] pack4(input logic [W-1:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    logic [W-1:0] q[$];
    logic [W-1:0] exp_word;
    int sent, recv;

    initial begin
        a_up_valid = 0; a_up_last = 0; a_wr_data = '0; a_down_ready = 0;
        b_up_valid = 0; b_up_last = 0; b_wr_data = '0; b_down_ready = 0;

        // reset state
        #1;
        check("rst_valid", a_down_valid, 0);
        check("rst_data",  a_rd_data, 0);
        check("rst_keep",  a_down_keep, 0);
        check("rst_last",  a_down_last, 0);
        check("rst_fill",  a_fill, 0);
        tick(); tick();
        rst = 1;
        check("rst_ready", a_up_ready, 1);

        // four words form one full beat; held under backpressure
        a_up_valid = 1;
        for (int i = 0; i < 4; i++) begin
            a_wr_data = W'(i + 1);
            check("fill_ready", a_up_ready, 1);
            check("fill_level", a_fill, 32'(i));
            tick();
        end
        a_wr_data = 7'h55;
        check("beat1_valid", a_down_valid, 1);
        check("beat1_data",  a_rd_data, pack4(7'h01, 7'h02, 7'h03, 7'h04));
        check("beat1_keep",  a_down_keep, 4'b1111);
        check("beat1_last",  a_down_last, 0);
        check("beat1_fill",  a_fill, 0);

        for (int k = 0; k < 5; k++) begin
            check("bp_ready", a_up_ready, 0);
            check("bp_valid", a_down_valid, 1);
            check("bp_data",  a_rd_data, pack4(7'h01, 7'h02, 7'h03, 7'h04));
            check("bp_keep",  a_down_keep, 4'b1111);
            tick();
        end
        a_down_ready = 1;
        #1;
        check("bp_release_ready", a_up_ready, 1);
        tick();
        check("lane0_valid", a_down_valid, 0);
        check("lane0_fill",  a_fill, 1);
        check("lane0_keep",  a_down_keep, 4'b0001);
        check("lane0_data",  a_rd_data, 32'h55);

        a_wr_data = 7'h66; a_up_last = 1; a_down_ready = 0;
        tick();
        check("flush_valid", a_down_valid, 1);
        check("flush_data",  a_rd_data, pack4(7'h55, 7'h66, 7'h00, 7'h00));
        check("flush_keep",  a_down_keep, 4'b0011);
        check("flush_last",  a_down_last, 1);
        a_up_valid = 0; a_up_last = 0; a_down_ready = 1;
        tick();
        check("drain_valid", a_down_valid, 0);
        check("drain_data",  a_rd_data, 0);
        check("drain_keep",  a_down_keep, 0);
        check("drain_last",  a_down_last, 0);

        // two-word group closed by up_last
        a_down_ready = 0; a_up_valid = 1; a_wr_data = 7'h11;
        tick();
        a_wr_data = 7'h22; a_up_last = 1;
        tick();
        a_up_valid = 0; a_up_last = 0;
        check("short_valid", a_down_valid, 1);
        check("short_data",  a_rd_data, pack4(7'h11, 7'h22, 7'h00, 7'h00));
        check("short_keep",  a_down_keep, 4'b0011);
        check("short_last",  a_down_last, 1);
        a_down_ready = 1;
        tick();
        check("short_gone", a_down_valid, 0);

        // up_last without up_valid has no effect
        a_up_last = 1;
        tick();
        check("idle_last_valid", a_down_valid, 0);
        check("idle_last_fill",  a_fill, 0);
        a_up_last = 0;

        // sustained streaming of 16 words
        a_up_valid = 1;
        for (int i = 0; i < 16; i++) begin
            a_wr_data = W'(i);
            check("stream_ready", a_up_ready, 1);
            check("stream_fill",  a_fill, 32'(i % 4));
            check("stream_valid", a_down_valid, 32'((i >= 4) && (i % 4 == 0)));
            if ((i >= 4) && (i % 4 == 0)) begin
                check("stream_data", a_rd_data, pack4(W'(i-4), W'(i-3), W'(i-2), W'(i-1)));
                check("stream_keep", a_down_keep, 4'b1111);
            end
            tick();
        end
        a_up_valid = 0;
        check("stream_last_valid", a_down_valid, 1);
        check("stream_last_data",  a_rd_data, pack4(7'd12, 7'd13, 7'd14, 7'd15));
        check("stream_last_keep",  a_down_keep, 4'b1111);
        tick();
        check("stream_drained", a_down_valid, 0);

        // asynchronous reset mid-group
        a_down_ready = 0; a_up_valid = 1; a_wr_data = 7'h7F;
        tick();
        a_wr_data = 7'h7E;
        tick();
        a_up_valid = 0;
        check("mid_fill", a_fill, 2);
        #2;
        rst = 0;
        #1;
        check("async_fill",  a_fill, 0);
        check("async_keep",  a_down_keep, 0);
        check("async_data",  a_rd_data, 0);
        check("async_valid", a_down_valid, 0);
        tick(); tick();
        rst = 1;
        a_up_valid = 1;
        for (int i = 0; i < 4; i++) begin
            a_wr_data = W'(8'h0A + i);
            tick();
        end
        a_up_valid = 0;
        check("post_rst_valid", a_down_valid, 1);
        check("post_rst_data",  a_rd_data, pack4(7'h0A, 7'h0B, 7'h0C, 7'h0D));
        check("post_rst_keep",  a_down_keep, 4'b1111);
        a_down_ready = 1;
        tick();

        // RATIO=1 pipeline with random backpressure
        sent = 0; recv = 0;
        for (int cyc = 0; cyc < 300 && recv < 8; cyc++) begin
            b_up_valid   = (sent < 8);
            b_wr_data    = W'(8'h30 + sent);
            b_down_ready = 1'($urandom_range(0, 1));
            #1;
            if (b_down_valid && b_down_ready) begin
                check("r1_nonempty", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    exp_word = q.pop_front();
                    check("r1_data", b_rd_data, exp_word);
                end
                check("r1_keep", b_down_keep, 1);
                check("r1_fill", b_fill, 0);
                recv++;
            end
            if (b_up_valid && b_up_ready) begin
                q.push_back(b_wr_data);
                sent++;
            end
            @(posedge clk);
            #1;
        end
        b_up_valid = 0;
        check("r1_recv",  recv, 8);
        check("r1_sent",  sent, 8);
        check("r1_queue", q.size(), 0);
        check("r1_idle",  b_down_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
